// File: rtl/vram_fetch_seq.sv
// Video-RAM fetch sequencer: slices each VRAM word into byte slots on CAS edges in video RAS
// windows, with an optional programmable slot delay and blanking on the delayed stream.
module vram_fetch_seq #(
    parameter int unsigned BYTES     = 2,
    parameter int unsigned MAX_SHIFT = 4,
    localparam int unsigned SHIFT_W  = $clog2(MAX_SHIFT + 1),
    localparam int unsigned BSEL_W   = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 cpu_n_i,
    input  logic                 ras_n_i,
    input  logic                 cas_n_i,
    input  logic                 crtc_de_i,
    input  logic [13:0]          ma_i,
    input  logic [4:0]           ra_i,
    input  logic [SHIFT_W-1:0]   shift_amt_i,
    input  logic [8*BYTES-1:0]   vram_din_i,
    output logic [14:0]          vram_addr_o,
    output logic [7:0]           vram_d_o,
    output logic                 byte_stb_o
);

    logic              cas_q;
    logic [BSEL_W-1:0] bsel_q, bsel_d;
    logic [7:0]        line_q [MAX_SHIFT];
    logic [7:0]        line_d [MAX_SHIFT];
    logic [14:0]       vram_addr_q, vram_addr_d;
    logic [7:0]        vram_d_q, vram_d_d;
    logic              byte_stb_q, byte_stb_d;

    logic              cap;
    logic [7:0]        cur_byte;
    logic [7:0]        tap;
    logic [SHIFT_W-1:0] shift_eff;

    always_comb begin
        // CAS rising edge inside a video RAS window
        cap = cpu_n_i & ~ras_n_i & ~cas_q & cas_n_i;

        cur_byte = '0;
        for (int k = 0; k < int'(BYTES); k++) begin
            if (bsel_q == BSEL_W'(k)) cur_byte = vram_din_i[8*k +: 8];
        end

        shift_eff = (shift_amt_i > SHIFT_W'(MAX_SHIFT)) ? SHIFT_W'(MAX_SHIFT) : shift_amt_i;

        tap = '0;
        for (int i = 0; i < int'(MAX_SHIFT); i++) begin
            if (shift_eff == SHIFT_W'(i + 1)) tap = line_q[i];
        end
    end

    always_comb begin
        bsel_d      = bsel_q;
        line_d      = line_q;
        vram_addr_d = vram_addr_q;
        vram_d_d    = vram_d_q;
        byte_stb_d  = 1'b0;

        if (!cpu_n_i) begin
            bsel_d = '0;
        end else begin
            vram_addr_d = {ma_i[13:12], ra_i[2:0], ma_i[9:0]};
            if (cap) begin
                // Extra CAS pulses past the last slot keep re-reading it
                bsel_d = (bsel_q == BSEL_W'(BYTES - 1)) ? bsel_q : bsel_q + BSEL_W'(1);
                line_d[0] = crtc_de_i ? cur_byte : 8'h00;
                for (int i = 1; i < int'(MAX_SHIFT); i++) begin
                    line_d[i] = line_q[i-1];
                end
                vram_d_d   = (shift_eff == '0) ? cur_byte : tap;
                byte_stb_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cas_q       <= 1'b1;
            bsel_q      <= '0;
            vram_addr_q <= '0;
            vram_d_q    <= '0;
            byte_stb_q  <= 1'b0;
            for (int i = 0; i < int'(MAX_SHIFT); i++) begin
                line_q[i] <= '0;
            end
        end else begin
            cas_q       <= cas_n_i;
            bsel_q      <= bsel_d;
            vram_addr_q <= vram_addr_d;
            vram_d_q    <= vram_d_d;
            byte_stb_q  <= byte_stb_d;
            line_q      <= line_d;
        end
    end

    assign vram_addr_o = vram_addr_q;
    assign vram_d_o    = vram_d_q;
    assign byte_stb_o  = byte_stb_q;

endmodule

// File: tb/tb_vram_fetch_seq.sv
// Directed bench for vram_fetch_seq: a 2-byte and a 4-byte instance share the timing inputs.
module tb_vram_fetch_seq;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        reset;
    logic        cpu_n, ras_n, cas_n, crtc_de;
    logic [13:0] ma;
    logic [4:0]  ra;
    logic [2:0]  shift_amt;
    logic [15:0] din2;
    logic [31:0] din4;
    logic [14:0] addr2, addr4;
    logic [7:0]  d2, d4;
    logic        stb2, stb4;

    int tests = 0;
    int fails = 0;
    int stb_cnt2 = 0;
    int stb_cnt4 = 0;
    int s0;

    vram_fetch_seq #(.BYTES(2), .MAX_SHIFT(4)) u2 (
        .clk_i(clk), .reset_i(reset), .cpu_n_i(cpu_n), .ras_n_i(ras_n), .cas_n_i(cas_n),
        .crtc_de_i(crtc_de), .ma_i(ma), .ra_i(ra), .shift_amt_i(shift_amt),
        .vram_din_i(din2), .vram_addr_o(addr2), .vram_d_o(d2), .byte_stb_o(stb2)
    );

    vram_fetch_seq #(.BYTES(4), .MAX_SHIFT(4)) u4 (
        .clk_i(clk), .reset_i(reset), .cpu_n_i(cpu_n), .ras_n_i(ras_n), .cas_n_i(cas_n),
        .crtc_de_i(crtc_de), .ma_i(ma), .ra_i(ra), .shift_amt_i(shift_amt),
        .vram_din_i(din4), .vram_addr_o(addr4), .vram_d_o(d4), .byte_stb_o(stb4)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(negedge clk) begin
        if (stb2 === 1'b1) stb_cnt2 <= stb_cnt2 + 1;
        if (stb4 === 1'b1) stb_cnt4 <= stb_cnt4 + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Low then high CAS; the cap edge has just happened on return
    task automatic cas_pulse();
        cas_n = 1'b0;
        tick();
        cas_n = 1'b1;
        tick();
    endtask

    task automatic cpu_pulse();
        cpu_n = 1'b0;
        ras_n = 1'b1;
        tick();
        tick();
        cpu_n = 1'b1;
        ras_n = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1; cpu_n = 1'b0; ras_n = 1'b1; cas_n = 1'b1; crtc_de = 1'b0;
        ma = '0; ra = '0; shift_amt = '0; din2 = '0; din4 = '0;
        tick();
        tick();
        check("rst_addr", 32'(addr2), 32'h0);
        check("rst_d", 32'(d2), 32'h0);
        check("rst_stb", 32'(stb2), 32'h0);
        reset = 1'b0;
        tick();

        // First cap after reset reads byte 0
        cpu_n = 1'b1; ras_n = 1'b0; ma = 14'h0155; din2 = 16'hA55A;
        tick();
        cas_pulse();
        check("post_rst_d", 32'(d2), 32'h5A);
        check("post_rst_stb", 32'(stb2), 32'h1);

        // Asynchronous reset with the clock stopped
        clk_en = 1'b0;
        #3;
        reset = 1'b1;
        #2;
        check("async_addr", 32'(addr2), 32'h0);
        check("async_d", 32'(d2), 32'h0);
        check("async_stb", 32'(stb2), 32'h0);
        clk_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        // Address mapping and bypass byte order
        ma = 14'h3ABC; ra = 5'h05; din2 = 16'h1234; din4 = 32'h0;
        tick();
        check("addr2", 32'(addr2), 32'h76BC);
        check("addr4", 32'(addr4), 32'h76BC);
        s0 = stb_cnt2;
        cas_pulse();
        check("byp_d0", 32'(d2), 32'h34);
        cas_pulse();
        check("byp_d1", 32'(d2), 32'h12);
        tick();
        check("byp_stb_low", 32'(stb2), 32'h0);
        tick();
        check("byp_stb_cnt", 32'(stb_cnt2 - s0), 32'd2);

        // Shift 1 on the 2-byte instance, blanking on the last slot
        do_reset();
        shift_amt = 3'd1; crtc_de = 1'b1; din2 = 16'h1122;
        cas_pulse();
        check("sh1_d0", 32'(d2), 32'h00);
        cas_pulse();
        check("sh1_d1", 32'(d2), 32'h22);
        cpu_pulse();
        check("sh1_hold", 32'(d2), 32'h22);
        din2 = 16'h3344;
        cas_pulse();
        check("sh1_d2", 32'(d2), 32'h11);
        crtc_de = 1'b0;
        cas_pulse();
        check("sh1_d3", 32'(d2), 32'h44);
        cas_pulse();
        check("sh1_blank", 32'(d2), 32'h00);

        // Shift 3 on the 4-byte instance, then clamp 7 -> 4
        do_reset();
        shift_amt = 3'd3; crtc_de = 1'b1; din4 = 32'h04030201;
        s0 = stb_cnt4;
        cas_pulse();
        check("sh3_d0", 32'(d4), 32'h00);
        cas_pulse();
        check("sh3_d1", 32'(d4), 32'h00);
        cas_pulse();
        check("sh3_d2", 32'(d4), 32'h00);
        cas_pulse();
        check("sh3_d3", 32'(d4), 32'h01);
        cpu_pulse();
        din4 = 32'h08070605;
        cas_pulse();
        check("sh3_d4", 32'(d4), 32'h02);
        cas_pulse();
        check("sh3_d5", 32'(d4), 32'h03);
        cas_pulse();
        check("sh3_d6", 32'(d4), 32'h04);
        cas_pulse();
        check("sh3_d7", 32'(d4), 32'h05);
        tick();
        tick();
        check("sh3_stb_cnt", 32'(stb_cnt4 - s0), 32'd8);
        cpu_pulse();
        shift_amt = 3'd7; din4 = 32'h0C0B0A09;
        cas_pulse();
        check("clamp_d0", 32'(d4), 32'h05);
        cas_pulse();
        check("clamp_d1", 32'(d4), 32'h06);

        // Saturating byte select and restart after CPU phase
        do_reset();
        shift_amt = 3'd0; din4 = 32'hDDCCBBAA;
        cas_pulse();
        check("sat_d0", 32'(d4), 32'hAA);
        cas_pulse();
        check("sat_d1", 32'(d4), 32'hBB);
        cas_pulse();
        check("sat_d2", 32'(d4), 32'hCC);
        cas_pulse();
        check("sat_d3", 32'(d4), 32'hDD);
        cas_pulse();
        check("sat_d4", 32'(d4), 32'hDD);
        cas_pulse();
        check("sat_d5", 32'(d4), 32'hDD);
        cpu_pulse();
        cas_pulse();
        check("restart_d", 32'(d4), 32'hAA);

        // CPU phase beginning on the CAS edge suppresses the capture
        cas_n = 1'b0;
        tick();
        cas_n = 1'b1; cpu_n = 1'b0;
        tick();
        check("coll_stb", 32'(stb4), 32'h0);
        check("coll_d", 32'(d4), 32'hAA);
        cpu_n = 1'b1;
        tick();
        cas_pulse();
        check("coll_next", 32'(d4), 32'hAA);
        cas_pulse();
        check("coll_next1", 32'(d4), 32'hBB);

        // CAS edge with RAS high is ignored
        ras_n = 1'b1;
        cas_pulse();
        check("ras_hi_stb", 32'(stb4), 32'h0);
        check("ras_hi_d", 32'(d4), 32'hBB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
